// File: rtl/door_motor_sequencer.sv
// Garage-door motor supervisor: input sync/debounce, dead-timed up/down drive sequencing, obstruction reversal, timeout FAULT.
// Latency: press -> DEAD next cycle, drive after DEAD_CYC more; no backpressure, all inputs are sampled levels.
module door_motor_sequencer #(
    parameter int DB_CYC      = 4,
    parameter int DEAD_CYC    = 3,
    parameter int TIMEOUT_CYC = 50,
    parameter int CNT_W       = 8
) (
    input  logic CLK,
    input  logic RST,
    input  logic Ac,
    input  logic Up_Max,
    input  logic Dn_Max,
    input  logic Obst,
    input  logic Clr,
    output logic UP_M,
    output logic Dn_M,
    output logic FAULT,
    output logic BUSY
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DEAD,
        ST_MV_UP,
        ST_MV_DN,
        ST_FAULT
    } state_t;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYC - 1);
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYC - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    // Bit order in the sync chain: {Obst, Dn_Max, Up_Max, Ac}
    logic [3:0] sync1_q, sync1_d;
    logic [3:0] sync2_q, sync2_d;
    logic       ac_s, up_s, dn_s, ob_s;

    logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
    logic             ac_db_q, ac_db_d;
    logic             ac_db_prev_q, ac_db_prev_d;
    logic             press;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             target_q, target_d;
    logic             last_dir_q, last_dir_d;

    logic             conflict;
    logic             timeout;
    logic [CNT_W-1:0] timer_inc;

    always_comb begin
        sync1_d = {Obst, Dn_Max, Up_Max, Ac};
        sync2_d = sync1_q;
    end

    assign ac_s = sync2_q[0];
    assign up_s = sync2_q[1];
    assign dn_s = sync2_q[2];
    assign ob_s = sync2_q[3];

    // Accept a new Ac level only after DB_CYC consecutive disagreeing samples
    always_comb begin
        db_cnt_d     = '0;
        ac_db_d      = ac_db_q;
        ac_db_prev_d = ac_db_q;
        if (ac_s != ac_db_q) begin
            if (db_cnt_q == DB_LAST) begin
                ac_db_d = ac_s;
            end else begin
                db_cnt_d = db_cnt_q + CNT_W'(1);
            end
        end
    end

    assign press     = ac_db_q & ~ac_db_prev_q;
    assign conflict  = up_s & dn_s;
    assign timeout   = (timer_q >= TO_LAST);
    assign timer_inc = (timer_q == CNT_MAX) ? timer_q : timer_q + CNT_W'(1);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            db_cnt_q     <= '0;
            ac_db_q      <= 1'b0;
            ac_db_prev_q <= 1'b0;
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            target_q     <= DIR_DN;
            last_dir_q   <= DIR_DN;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            db_cnt_q     <= db_cnt_d;
            ac_db_q      <= ac_db_d;
            ac_db_prev_q <= ac_db_prev_d;
            state_q      <= state_d;
            timer_q      <= timer_d;
            target_q     <= target_d;
            last_dir_q   <= last_dir_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        last_dir_d = last_dir_q;
        timer_d    = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (conflict) begin
                    state_d = ST_FAULT;
                end else if (press) begin
                    state_d = ST_DEAD;
                    if (dn_s && !up_s) begin
                        target_d = DIR_UP;
                    end else if (up_s && !dn_s) begin
                        target_d = DIR_DN;
                    end else begin
                        target_d = ~last_dir_q;
                    end
                end
            end
            ST_DEAD: begin
                timer_d = timer_inc;
                if (conflict) begin
                    state_d = ST_FAULT;
                end else if (press) begin
                    state_d = ST_IDLE;
                end else if (timer_q == DEAD_LAST) begin
                    state_d    = (target_q == DIR_UP) ? ST_MV_UP : ST_MV_DN;
                    last_dir_d = target_q;
                end
            end
            ST_MV_UP: begin
                timer_d = timer_inc;
                if (conflict || timeout) begin
                    state_d = ST_FAULT;
                end else if (up_s || press) begin
                    state_d = ST_IDLE;
                end
            end
            ST_MV_DN: begin
                timer_d = timer_inc;
                if (conflict || timeout) begin
                    state_d = ST_FAULT;
                end else if (dn_s) begin
                    state_d = ST_IDLE;
                end else if (ob_s) begin
                    // Reversal goes through DEAD so the drive never flips directly
                    state_d  = ST_DEAD;
                    target_d = DIR_UP;
                end else if (press) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FAULT: begin
                if (Clr && !conflict) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (state_d != state_q) begin
            timer_d = '0;
        end
    end

    always_comb begin
        UP_M  = 1'b0;
        Dn_M  = 1'b0;
        FAULT = 1'b0;
        BUSY  = 1'b0;
        unique case (state_q)
            ST_DEAD:  BUSY = 1'b1;
            ST_MV_UP: begin
                UP_M = 1'b1;
                BUSY = 1'b1;
            end
            ST_MV_DN: begin
                Dn_M = 1'b1;
                BUSY = 1'b1;
            end
            ST_FAULT: FAULT = 1'b1;
            default:  BUSY = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_door_motor_sequencer.sv
// Directed bench for door_motor_sequencer; outputs checked as {UP_M, Dn_M, FAULT, BUSY} one cycle-step at a time.
module tb_door_motor_sequencer;

    logic CLK;
    logic RST;
    logic Ac, Up_Max, Dn_Max, Obst, Clr;
    logic UP_M, Dn_M, FAULT, BUSY;
    logic [3:0] outs;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [3:0] O_IDLE = 4'b0000;
    localparam logic [3:0] O_DEAD = 4'b0001;
    localparam logic [3:0] O_UP   = 4'b1001;
    localparam logic [3:0] O_DN   = 4'b0101;
    localparam logic [3:0] O_FLT  = 4'b0010;

    door_motor_sequencer dut (
        .CLK    (CLK),
        .RST    (RST),
        .Ac     (Ac),
        .Up_Max (Up_Max),
        .Dn_Max (Dn_Max),
        .Obst   (Obst),
        .Clr    (Clr),
        .UP_M   (UP_M),
        .Dn_M   (Dn_M),
        .FAULT  (FAULT),
        .BUSY   (BUSY)
    );

    assign outs = {UP_M, Dn_M, FAULT, BUSY};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic test_reset;
        RST = 1'b1; Ac = 1'b0; Up_Max = 1'b0; Dn_Max = 1'b0; Obst = 1'b0; Clr = 1'b0;
        #2 RST = 1'b0;
        #1;
        n_vec++;
        if (outs !== O_IDLE) begin n_err++; $display("FAIL reset_async: outs=%b expected %b", outs, O_IDLE); end
        tick(2);
        n_vec++;
        if (outs !== O_IDLE) begin n_err++; $display("FAIL reset_hold: outs=%b expected %b", outs, O_IDLE); end
        RST = 1'b1;
        tick(3);
        n_vec++;
        if (outs !== O_IDLE) begin n_err++; $display("FAIL post_reset: outs=%b expected %b", outs, O_IDLE); end
    endtask

    // Door closed, one clean press: 2 sync + 4 debounce + 1 press cycles to DEAD, 3 DEAD cycles, then UP
    task automatic test_open_from_closed;
        Dn_Max = 1'b1;
        tick(8);
        Ac = 1'b1;
        tick(6);
        n_vec++;
        if (outs !== O_IDLE) begin n_err++; $display("FAIL press_latency_pre: outs=%b expected %b", outs, O_IDLE); end
        tick(1);
        n_vec++;
        if (outs !== O_DEAD) begin n_err++; $display("FAIL dead_entry: outs=%b expected %b", outs, O_DEAD); end
        tick(2);
        n_vec++;
        if (outs !== O_DEAD) begin n_err++; $display("FAIL dead_hold: outs=%b expected %b", outs, O_DEAD); end
        tick(1);
        n_vec++;
        if (outs !== O_UP) begin n_err++; $display("FAIL up_start: outs=%b expected %b", outs, O_UP); end
        Ac = 1'b0;
        Dn_Max = 1'b0;
        tick(5);
        Up_Max = 1'b1;
        tick(2);
        n_vec++;
        if (outs !== O_UP) begin n_err++; $display("FAIL up_limit_sync: outs=%b expected %b", outs, O_UP); end
        tick(1);
        n_vec++;
        if (outs !== O_IDLE) begin n_err++; $display("FAIL up_limit_stop: outs=%b expected %b", outs, O_IDLE); end
    endtask

    task automatic test_debounce;
        tick(8);
        for (int i = 0; i < 20; i++) begin
            Ac = ~Ac;
            tick(1);
            n_vec++;
            if (outs !== O_IDLE) begin n_err++; $display("FAIL bounce_%0d: outs=%b expected %b", i, outs, O_IDLE); end
        end
        Ac = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            n_vec++;
            if (outs !== O_IDLE) begin n_err++; $display("FAIL bounce_settle_%0d: outs=%b expected %b", i, outs, O_IDLE); end
        end
    endtask

    // Fully open, press -> down; obstruction at cycle 10 of travel reverses through DEAD
    task automatic test_obstruction;
        tick(4);
        Ac = 1'b1;
        tick(7);
        n_vec++;
        if (outs !== O_DEAD) begin n_err++; $display("FAIL rev_dead: outs=%b expected %b", outs, O_DEAD); end
        tick(3);
        n_vec++;
        if (outs !== O_DN) begin n_err++; $display("FAIL dn_start: outs=%b expected %b", outs, O_DN); end
        Ac = 1'b0;
        Up_Max = 1'b0;
        tick(9);
        n_vec++;
        if (outs !== O_DN) begin n_err++; $display("FAIL dn_cycle10: outs=%b expected %b", outs, O_DN); end
        Obst = 1'b1;
        tick(2);
        n_vec++;
        if (outs !== O_DN) begin n_err++; $display("FAIL obst_sync: outs=%b expected %b", outs, O_DN); end
        tick(1);
        n_vec++;
        if (outs !== O_DEAD) begin n_err++; $display("FAIL obst_reverse: outs=%b expected %b", outs, O_DEAD); end
        tick(2);
        n_vec++;
        if (outs !== O_DEAD) begin n_err++; $display("FAIL reverse_dead_hold: outs=%b expected %b", outs, O_DEAD); end
        tick(1);
        n_vec++;
        if (outs !== O_UP) begin n_err++; $display("FAIL reverse_up: outs=%b expected %b", outs, O_UP); end
    endtask

    // Continues from the first MV_UP cycle of the reversal with no limit ever reached
    task automatic test_timeout;
        tick(10);
        n_vec++;
        if (outs !== O_UP) begin n_err++; $display("FAIL obst_ignored_up: outs=%b expected %b", outs, O_UP); end
        Obst = 1'b0;
        tick(39);
        n_vec++;
        if (outs !== O_UP) begin n_err++; $display("FAIL timeout_edge: outs=%b expected %b", outs, O_UP); end
        tick(1);
        n_vec++;
        if (outs !== O_FLT) begin n_err++; $display("FAIL timeout_fault: outs=%b expected %b", outs, O_FLT); end
        Ac = 1'b1;
        tick(10);
        Ac = 1'b0;
        tick(8);
        n_vec++;
        if (outs !== O_FLT) begin n_err++; $display("FAIL press_ignored: outs=%b expected %b", outs, O_FLT); end
        Clr = 1'b1;
        tick(1);
        n_vec++;
        if (outs !== O_IDLE) begin n_err++; $display("FAIL clr_exit: outs=%b expected %b", outs, O_IDLE); end
        Clr = 1'b0;
    endtask

    task automatic test_conflict;
        tick(3);
        Up_Max = 1'b1;
        Dn_Max = 1'b1;
        tick(2);
        n_vec++;
        if (outs !== O_IDLE) begin n_err++; $display("FAIL conflict_sync: outs=%b expected %b", outs, O_IDLE); end
        tick(1);
        n_vec++;
        if (outs !== O_FLT) begin n_err++; $display("FAIL conflict_fault: outs=%b expected %b", outs, O_FLT); end
        Clr = 1'b1;
        tick(4);
        n_vec++;
        if (outs !== O_FLT) begin n_err++; $display("FAIL clr_blocked: outs=%b expected %b", outs, O_FLT); end
        Up_Max = 1'b0;
        tick(2);
        n_vec++;
        if (outs !== O_FLT) begin n_err++; $display("FAIL clr_release_sync: outs=%b expected %b", outs, O_FLT); end
        tick(1);
        n_vec++;
        if (outs !== O_IDLE) begin n_err++; $display("FAIL clr_release_exit: outs=%b expected %b", outs, O_IDLE); end
        Clr = 1'b0;
    endtask

    // Closed door -> up, stop mid-travel, restart goes down (opposite of last motion), then async reset
    task automatic test_mid_stop;
        tick(3);
        Ac = 1'b1;
        tick(10);
        n_vec++;
        if (outs !== O_UP) begin n_err++; $display("FAIL mid_up_start: outs=%b expected %b", outs, O_UP); end
        Ac = 1'b0;
        Dn_Max = 1'b0;
        tick(8);
        Ac = 1'b1;
        tick(6);
        n_vec++;
        if (outs !== O_UP) begin n_err++; $display("FAIL stop_pre: outs=%b expected %b", outs, O_UP); end
        tick(1);
        n_vec++;
        if (outs !== O_IDLE) begin n_err++; $display("FAIL stop_press: outs=%b expected %b", outs, O_IDLE); end
        tick(3);
        Ac = 1'b0;
        tick(8);
        Ac = 1'b1;
        tick(7);
        n_vec++;
        if (outs !== O_DEAD) begin n_err++; $display("FAIL restart_dead: outs=%b expected %b", outs, O_DEAD); end
        tick(3);
        n_vec++;
        if (outs !== O_DN) begin n_err++; $display("FAIL restart_down: outs=%b expected %b", outs, O_DN); end
        Ac = 1'b0;
        tick(3);
        RST = 1'b0;
        #1;
        n_vec++;
        if (outs !== O_IDLE) begin n_err++; $display("FAIL rst_async_drop: outs=%b expected %b", outs, O_IDLE); end
        #3 RST = 1'b1;
        tick(2);
        n_vec++;
        if (outs !== O_IDLE) begin n_err++; $display("FAIL rst_recover: outs=%b expected %b", outs, O_IDLE); end
    endtask

    initial begin
        test_reset();
        test_open_from_closed();
        test_debounce();
        test_obstruction();
        test_timeout();
        test_conflict();
        test_mid_stop();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
